// File: rtl/pll_nco_multi_if.sv
// Configuration write bus for pll_nco_multi: valid/ready handshake plus
// channel select, tuning word, phase preload and a one-cycle error pulse.
interface pll_nco_multi_if #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned ACC_W  = 32
) ();
    localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CW-1:0]    cfg_chan;
    logic [ACC_W-1:0] cfg_ftw;
    logic [ACC_W-1:0] cfg_phase;
    logic             cfg_err;

    modport master (
        output cfg_valid,
        output cfg_chan,
        output cfg_ftw,
        output cfg_phase,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_chan,
        input  cfg_ftw,
        input  cfg_phase,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/pll_nco_multi.sv
// Multi-channel NCO clock synthesiser: per-channel phase accumulators driven
// from one reference clock, with a shared settle/lock FSM gating retunes.
module pll_nco_multi #(
    parameter int unsigned      NUM_CH      = 2,
    parameter int unsigned      ACC_W       = 32,
    parameter int unsigned      LOCK_CYCLES = 1024,
    parameter logic [ACC_W-1:0] FTW_INIT    = '0
) (
    input  logic              refclk,
    input  logic              rst,
    pll_nco_multi_if.slave    cfg,
    output logic [NUM_CH-1:0] outclk,
    output logic [NUM_CH-1:0] tick,
    output logic              locked
);
    localparam int unsigned CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CNT_W = 20;
    localparam logic [CNT_W-1:0] CntLoad = CNT_W'(LOCK_CYCLES - 1);

    typedef enum logic {StSettle, StLocked} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic [ACC_W-1:0] acc_q [NUM_CH];
    logic [ACC_W-1:0] acc_d [NUM_CH];
    logic [ACC_W-1:0] ftw_q [NUM_CH];
    logic [ACC_W-1:0] ftw_d [NUM_CH];
    logic [ACC_W:0]   sum   [NUM_CH];
    logic [NUM_CH-1:0] tick_q, tick_d;

    logic accept;
    logic chan_ok;
    logic wr_ok;

    assign accept  = cfg.cfg_valid & (state_q == StLocked);
    assign chan_ok = (32'(cfg.cfg_chan) < NUM_CH);
    assign wr_ok   = accept & chan_ok;

    // Lock FSM: the counter holds the number of SETTLE edges still to go
    // before the one that moves to LOCKED.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = accept & ~chan_ok;
        unique case (state_q)
            StSettle: begin
                if (cnt_q == '0) begin
                    state_d = StLocked;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StLocked: begin
                if (wr_ok) begin
                    state_d = StSettle;
                    cnt_d   = CntLoad;
                end
            end
            default: begin
                state_d = StSettle;
                cnt_d   = CntLoad;
            end
        endcase
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            sum[c]    = {1'b0, acc_q[c]} + {1'b0, ftw_q[c]};
            acc_d[c]  = sum[c][ACC_W-1:0];
            tick_d[c] = sum[c][ACC_W];
            ftw_d[c]  = ftw_q[c];
            if (wr_ok && (cfg.cfg_chan == CW'(c))) begin
                acc_d[c]  = cfg.cfg_phase;
                ftw_d[c]  = cfg.cfg_ftw;
                tick_d[c] = 1'b0;
            end
        end
    end

    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            state_q <= StSettle;
            cnt_q   <= CntLoad;
            err_q   <= 1'b0;
            tick_q  <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                acc_q[c] <= '0;
                ftw_q[c] <= FTW_INIT;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            tick_q  <= tick_d;
            for (int c = 0; c < NUM_CH; c++) begin
                acc_q[c] <= acc_d[c];
                ftw_q[c] <= ftw_d[c];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            outclk[c] = acc_q[c][ACC_W-1];
        end
    end

    assign tick          = tick_q;
    assign locked        = (state_q == StLocked);
    assign cfg.cfg_ready = (state_q == StLocked);
    assign cfg.cfg_err   = err_q;
endmodule

// File: tb/tb_pll_nco_multi.sv
// Directed bench for pll_nco_multi (3 channels, 8-bit accumulators, 16-cycle
// settle); expected waveforms are hand-derived per channel from elapsed cycles.
module tb_pll_nco_multi;
    logic       refclk = 1'b0;
    logic       rst;
    logic [2:0] outclk;
    logic [2:0] tick;
    logic       locked;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Cycle stamps of the sample taken right after each channel's write edge.
    int t0, t1, t2;
    bit act0 = 0, act1 = 0, act2 = 0;

    // ch1 (ftw=96, phase=128): acc 128,224,64,160,0,96,192,32 repeating.
    logic [7:0] oc1_pat = 8'b0100_1011;
    logic [7:0] tk1_pat = 8'b1001_0100;

    pll_nco_multi_if #(.NUM_CH(3), .ACC_W(8)) cfg_if ();

    pll_nco_multi #(
        .NUM_CH     (3),
        .ACC_W      (8),
        .LOCK_CYCLES(16),
        .FTW_INIT   (8'd0)
    ) dut (
        .refclk(refclk),
        .rst   (rst),
        .cfg   (cfg_if),
        .outclk(outclk),
        .tick  (tick),
        .locked(locked)
    );

    always #5 refclk = ~refclk;

    task automatic step();
        @(posedge refclk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_chans();
        logic [2:0] exp_oc;
        logic [2:0] exp_tk;
        int k, j, m;
        exp_oc = '0;
        exp_tk = '0;
        if (act0) begin
            k = cyc - t0;
            exp_oc[0] = ((k % 4) >= 2);
            exp_tk[0] = (k > 0) && ((k % 4) == 0);
        end
        if (act1) begin
            j = cyc - t1;
            exp_oc[1] = oc1_pat[j % 8];
            exp_tk[1] = (j > 0) && tk1_pat[j % 8];
        end
        if (act2) begin
            m = cyc - t2;
            exp_oc[2] = ((m % 256) >= 128);
            exp_tk[2] = (m > 0) && ((m % 256) == 0);
        end
        chk("outclk", 32'(outclk), 32'(exp_oc));
        chk("tick", 32'(tick), 32'(exp_tk));
    endtask

    task automatic drive_cfg(input bit v, input logic [1:0] ch, input logic [7:0] f,
                             input logic [7:0] p);
        cfg_if.cfg_valid = v;
        cfg_if.cfg_chan  = ch;
        cfg_if.cfg_ftw   = f;
        cfg_if.cfg_phase = p;
    endtask

    initial begin
        rst = 1'b0;
        drive_cfg(1'b0, 2'd0, 8'd0, 8'd0);

        // 1: reset state, then 16-edge settle
        step();
        step();
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_ready", 32'(cfg_if.cfg_ready), 32'd0);
        chk("rst_err", 32'(cfg_if.cfg_err), 32'd0);
        check_chans();
        rst = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            chk("settle_locked", 32'(locked), 32'(k == 16));
            chk("settle_ready", 32'(cfg_if.cfg_ready), 32'(k == 16));
            check_chans();
        end

        // 2: ch0 ftw=64 phase=0
        drive_cfg(1'b1, 2'd0, 8'd64, 8'd0);
        step();
        t0 = cyc;
        act0 = 1;
        drive_cfg(1'b0, 2'd0, 8'd0, 8'd0);
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) step();
            chk("ch0_locked", 32'(locked), 32'(k == 16));
            chk("ch0_ready", 32'(cfg_if.cfg_ready), 32'(k == 16));
            check_chans();
        end

        // 3: ch1 ftw=96 phase=128; 4: ch2 request held through SETTLE
        drive_cfg(1'b1, 2'd1, 8'd96, 8'd128);
        step();
        t1 = cyc;
        act1 = 1;
        drive_cfg(1'b0, 2'd0, 8'd0, 8'd0);
        for (int j = 0; j <= 16; j++) begin
            if (j > 0) step();
            if (j == 1) drive_cfg(1'b1, 2'd2, 8'd1, 8'd0);
            chk("ch1_locked", 32'(locked), 32'(j == 16));
            check_chans();
        end
        step();
        t2 = cyc;
        act2 = 1;
        drive_cfg(1'b0, 2'd0, 8'd0, 8'd0);
        for (int m = 0; m <= 260; m++) begin
            if (m > 0) step();
            chk("ch2_locked", 32'(locked), 32'(m >= 16));
            check_chans();
        end

        // 5: invalid channel
        drive_cfg(1'b1, 2'd3, 8'd77, 8'd5);
        step();
        drive_cfg(1'b0, 2'd0, 8'd0, 8'd0);
        chk("err_pulse", 32'(cfg_if.cfg_err), 32'd1);
        chk("err_locked", 32'(locked), 32'd1);
        chk("err_ready", 32'(cfg_if.cfg_ready), 32'd1);
        check_chans();
        for (int n = 0; n < 8; n++) begin
            step();
            chk("err_clear", 32'(cfg_if.cfg_err), 32'd0);
            chk("err_still_locked", 32'(locked), 32'd1);
            check_chans();
        end

        // 6: reset 5 cycles into a SETTLE
        drive_cfg(1'b1, 2'd0, 8'd32, 8'd0);
        step();
        act0 = 0;
        drive_cfg(1'b0, 2'd0, 8'd0, 8'd0);
        for (int n = 0; n < 5; n++) begin
            step();
            chk("pre_rst_locked", 32'(locked), 32'd0);
            chk("pre_rst_tick1", 32'(tick[1]), 32'(((cyc - t1) > 0) && tk1_pat[(cyc - t1) % 8]));
        end
        rst = 1'b0;
        act1 = 0;
        act2 = 0;
        #2;
        chk("async_locked", 32'(locked), 32'd0);
        chk("async_ready", 32'(cfg_if.cfg_ready), 32'd0);
        check_chans();
        step();
        rst = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            chk("resettle_locked", 32'(locked), 32'(k == 16));
            check_chans();
        end
        for (int n = 0; n < 8; n++) begin
            step();
            chk("frozen_locked", 32'(locked), 32'd1);
            check_chans();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pll_nco_multi.md
Name: pll_nco_multi

Overview:
- Parametrised, multi-channel successor to the single-output fixed PLL wrapper.
- Synthesises NUM_CH run-time-programmable fractional clocks from one reference clock, using per-channel phase accumulators (NCOs).
- Each channel provides a near-50% duty square-wave outclk and a one-cycle clock-enable tick.
- A shared lock FSM asserts locked after every reset and every retune, so downstream logic (ADC/DAC drivers for voltage control) waits for stable rates exactly as it waits on the hard-PLL lock.

Parameters:
- NUM_CH, 2, number of output channels (>=1).
- ACC_W, 32, phase-accumulator and tuning-word width (>=4).
- LOCK_CYCLES, 1024, settle time in refclk cycles after reset or accepted write (>=1, <2^20).
- FTW_INIT, 0, frequency tuning word loaded into every channel at reset.

Ports:
- refclk  in  1  sole clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  config write may be accepted.
- cfg_chan  in  CW=max(1,clog2(NUM_CH))  target channel.
- cfg_ftw  in  ACC_W  new tuning word; f_out = f_refclk*ftw/2^ACC_W.
- cfg_phase  in  ACC_W  accumulator preload value.
- cfg_err  out  1  one-cycle pulse: accepted write had cfg_chan>=NUM_CH.
- outclk  out  NUM_CH  bit c = MSB of acc[c].
- tick  out  NUM_CH  bit c = 1 for the cycle after acc[c] wraps.
- locked  out  1  all channels settled.

Behaviour:
- Reset (rst=0, async):
  - acc[c]=0, ftw[c]=FTW_INIT.
  - outclk=0, tick=0, cfg_err=0, locked=0, cfg_ready=0.
  - Settle counter loaded; FSM=SETTLE.
- Accumulator, every edge unless loaded:
  - {carry, acc[c]} <= acc[c] + ftw[c], arithmetic modulo 2^ACC_W.
  - tick[c] <= carry.
  - ftw=0 freezes the channel: outclk constant, no ticks.
  - ftw >= 2^(ACC_W-1) is legal; output aliases, no error is raised.
- Lock FSM, two states:
  - SETTLE: cfg_ready=0, locked=0; counter decrements each edge. Transition to LOCKED on the LOCK_CYCLES-th edge after entry (after rst deassertion, or after the acceptance edge). locked and cfg_ready rise on that same edge.
  - LOCKED: cfg_ready=1, locked=1.
- Write acceptance: cfg_valid & cfg_ready at an edge (T). Writes are accepted only in LOCKED.
- Valid channel, at edge T:
  - ftw[chan] <= cfg_ftw, acc[chan] <= cfg_phase, tick[chan] <= 0.
  - FSM <= SETTLE with counter reloaded, so locked=0 and cfg_ready=0 from T+1.
  - Other channels keep running with no discontinuity.
- Invalid channel (cfg_chan>=NUM_CH):
  - cfg_err=1 for the single cycle after T.
  - No register change, no relock; stays LOCKED.
- cfg_valid held while cfg_ready=0: no effect. Master holds cfg_valid/data stable until acceptance; no internal queuing.
- Reset asserted mid-SETTLE or mid-write: immediate return to reset values. Pending cfg is discarded. Programmed ftw values are lost (revert to FTW_INIT).
- outclk and tick are registered; no combinational path from inputs to outputs.

Test Plan:
(NUM_CH=3, ACC_W=8, LOCK_CYCLES=16, FTW_INIT=0 unless noted)
1. Release rst -> locked=0, cfg_ready=0 for edges 1..15; both rise on edge 16. outclk=000 and tick=000 throughout.
2. Write ch0 ftw=64 phase=0 -> locked falls next cycle. acc0 runs 0,64,128,192,0. outclk0 pattern 0,0,1,1 (period 4); tick0 once every 4 cycles. locked rises 16 edges after acceptance.
3. Write ch1 ftw=96 phase=128 -> acc1 runs 128,224,64,160,0,96,192,32. Exactly 3 ticks per 8 cycles. ch0 period-4 pattern continues unbroken across the write.
4. Hold cfg_valid during SETTLE with ch2 ftw=1 -> nothing accepted until cfg_ready=1. Exactly one acceptance follows; ch2 tick period 256.
5. In LOCKED, write cfg_chan=3 -> cfg_err=1 for one cycle. locked stays 1 and all ftw are unchanged.
6. Assert rst 5 cycles into SETTLE, then release -> outputs zero immediately; ftw all 0. Full 16-cycle settle before locked=1.
